// File: rtl/pyj96_arbiter.sv
// pyj96_arbiter: two-port round-robin front end that feeds one job at a time
// byte-serially into a cipher core and returns the 96-bit result or a timeout.
module pyj96_arbiter #(
   parameter int TIMEOUT = 255
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         req0,
   input  logic         req1,
   input  logic [95:0]  pt0,
   input  logic [95:0]  pt1,
   input  logic [127:0] key0,
   input  logic [127:0] key1,
   output logic         gnt0,
   output logic         gnt1,
   output logic         done0,
   output logic         done1,
   output logic         err0,
   output logic         err1,
   output logic [95:0]  ct_o,
   output logic         busy,
   output logic         core_load,
   output logic         core_start,
   output logic [7:0]   core_byte_in,
   output logic [7:0]   core_key_in,
   input  logic         core_valid,
   input  logic [7:0]   core_byte_out
);
   typedef enum logic [2:0] {IDLE, GRANT, LOAD, START, WAIT, COLLECT, RESP} state_t;
   state_t state_q, state_d;
   logic ptr_q, ptr_d, sel_q, sel_d, abort_q, abort_d;
   logic [15:0] cnt_q, cnt_d;
   logic [11:0][7:0] pt_q, pt_d;
   logic [15:0][7:0] key_q, key_d;
   logic [95:0] ct_q, ct_d;
   logic [1:0] gnt_q, gnt_d, done_q, done_d, err_q, err_d;
   logic [95:0] ct_o_q, ct_o_d;
   logic busy_q, busy_d, core_load_q, core_load_d, core_start_q, core_start_d;
   logic [7:0] core_byte_in_q, core_byte_in_d, core_key_in_q, core_key_in_d;
   // cnt_q is the LOAD byte index, the WAIT cycle counter and the COLLECT byte count
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      abort_d = abort_q;
      cnt_d   = cnt_q;
      pt_d    = pt_q;
      key_d   = key_q;
      ct_d    = ct_q;
      case (state_q)
         IDLE: if (req0 | req1) begin
            sel_d   = (req0 & req1) ? ptr_q : req1;
            ptr_d   = ~sel_d;
            pt_d    = sel_d ? pt1 : pt0;
            key_d   = sel_d ? key1 : key0;
            abort_d = 1'b0;
            cnt_d   = '0;
            state_d = GRANT;
         end
         GRANT: state_d = LOAD;
         LOAD: begin
            cnt_d = cnt_q + 16'd1;
            if (cnt_q == 16'd15) begin
               cnt_d   = '0;
               state_d = START;
            end
         end
         START: state_d = WAIT;
         WAIT: if (core_valid) begin
            ct_d    = {ct_q[87:0], core_byte_out};
            cnt_d   = 16'd1;
            state_d = COLLECT;
         end else begin
            cnt_d = cnt_q + 16'd1;
            if (cnt_d == 16'(TIMEOUT)) begin
               abort_d = 1'b1;
               state_d = RESP;
            end
         end
         COLLECT: if (core_valid) begin
            ct_d  = {ct_q[87:0], core_byte_out};
            cnt_d = cnt_q + 16'd1;
            if (cnt_q == 16'd11) state_d = RESP;
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   // Outputs are computed from the next state so the registered copies line up with the state
   always_comb begin
      gnt_d          = (state_d == GRANT) ? (sel_d ? 2'b10 : 2'b01) : 2'b00;
      done_d         = (state_d == RESP && !abort_d) ? (sel_d ? 2'b10 : 2'b01) : 2'b00;
      err_d          = (state_d == RESP && abort_d) ? (sel_d ? 2'b10 : 2'b01) : 2'b00;
      ct_o_d         = (state_d == RESP && !abort_d) ? ct_d : '0;
      busy_d         = state_d != IDLE;
      core_load_d    = state_d == LOAD;
      core_start_d   = state_d == START;
      core_key_in_d  = (state_d == LOAD) ? key_q[4'd15 - cnt_d[3:0]] : 8'h00;
      core_byte_in_d = (state_d == LOAD && cnt_d[3:0] < 4'd12) ? pt_q[4'd11 - cnt_d[3:0]] : 8'h00;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= IDLE;
         ptr_q          <= 1'b0;
         sel_q          <= 1'b0;
         abort_q        <= 1'b0;
         cnt_q          <= '0;
         pt_q           <= '0;
         key_q          <= '0;
         ct_q           <= '0;
         gnt_q          <= '0;
         done_q         <= '0;
         err_q          <= '0;
         ct_o_q         <= '0;
         busy_q         <= 1'b0;
         core_load_q    <= 1'b0;
         core_start_q   <= 1'b0;
         core_byte_in_q <= '0;
         core_key_in_q  <= '0;
      end else begin
         state_q        <= state_d;
         ptr_q          <= ptr_d;
         sel_q          <= sel_d;
         abort_q        <= abort_d;
         cnt_q          <= cnt_d;
         pt_q           <= pt_d;
         key_q          <= key_d;
         ct_q           <= ct_d;
         gnt_q          <= gnt_d;
         done_q         <= done_d;
         err_q          <= err_d;
         ct_o_q         <= ct_o_d;
         busy_q         <= busy_d;
         core_load_q    <= core_load_d;
         core_start_q   <= core_start_d;
         core_byte_in_q <= core_byte_in_d;
         core_key_in_q  <= core_key_in_d;
      end
   end
   assign gnt0         = gnt_q[0];
   assign gnt1         = gnt_q[1];
   assign done0        = done_q[0];
   assign done1        = done_q[1];
   assign err0         = err_q[0];
   assign err1         = err_q[1];
   assign ct_o         = ct_o_q;
   assign busy         = busy_q;
   assign core_load    = core_load_q;
   assign core_start   = core_start_q;
   assign core_byte_in = core_byte_in_q;
   assign core_key_in  = core_key_in_q;
endmodule
